accum_avg_tx: RTL and testbench

Reader and transmitter for the TDC accumulation sum. Takes each 20-bit accumulated sum when its strobe fires, removes the fixed per-sample offset, and divides by the sample count to get a 16-bit mean. It then ships the mean off-chip as a 4-byte UART 8N1 frame. It sits between the accumulation stage and the board UART pin, with one pending-sum buffer so back-to-back sums are not lost.

---
 rtl/accum_avg_tx.sv | 167 ++++++++++++++++
 tb/tb_accum_avg_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_avg_tx.sv
// Averages each 20-bit TDC accumulation sum (offset removal, restoring divide,
// 16-bit saturation) and transmits the mean as a 4-byte UART 8N1 frame.
`timescale 1ns/1ps

module accum_avg_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned N_SAMPLES    = 9,
    parameter int unsigned SUM_OFFSET   = 162
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] result,
    input  logic        result_valid,
    input  logic        ovr_clr,
    output logic        tx,
    output logic        busy,
    output logic [15:0] avg_out,
    output logic        avg_valid,
    output logic        overrun
);

    localparam int unsigned SUM_W   = 20;
    localparam int unsigned REM_W   = 21;
    localparam int unsigned AVG_W   = 16;
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned POS_W   = 6;
    localparam int unsigned DIV_W   = 5;
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [7:0]  SYNC    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        DIV,
        SAT,
        SEND
    } state_t;

    state_t               state;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     dvd;
    logic [REM_W-1:0]     rem;
    logic [DIV_W-1:0]     div_cnt;
    logic [SUM_W-1:0]     pend;
    logic                 pend_full;
    logic [FRAME_W-1:0]   frame;
    logic [POS_W-1:0]     bit_pos;
    logic [CNT_W-1:0]     clk_cnt;

    logic [SUM_W-1:0]     adj_c;
    logic [REM_W-1:0]     rem_shift_c;
    logic [REM_W-1:0]     rem_next_c;
    logic                 q_bit_c;
    logic [AVG_W-1:0]     avg_sat_c;
    logic [7:0]           chk_c;
    logic [FRAME_W-1:0]   frame_c;
    logic                 ovr_set_c;

    // Datapath helpers: offset clamp, one restoring-divide step, saturation, framing
    always_comb begin
        adj_c       = '0;
        rem_shift_c = REM_W'({rem, dvd[SUM_W-1]});
        q_bit_c     = 1'b0;
        rem_next_c  = rem_shift_c;
        if (sum >= SUM_W'(SUM_OFFSET)) begin
            adj_c = sum - SUM_W'(SUM_OFFSET);
        end
        if (rem_shift_c >= REM_W'(N_SAMPLES)) begin
            q_bit_c    = 1'b1;
            rem_next_c = rem_shift_c - REM_W'(N_SAMPLES);
        end
        avg_sat_c = (|dvd[SUM_W-1:AVG_W]) ? 16'hFFFF : dvd[AVG_W-1:0];
        chk_c     = SYNC ^ avg_sat_c[15:8] ^ avg_sat_c[7:0];
        // Bit 0 is the first bit on the wire; each byte is {stop, data, start}
        frame_c   = {1'b1, chk_c,           1'b0,
                     1'b1, avg_sat_c[7:0],  1'b0,
                     1'b1, avg_sat_c[15:8], 1'b0,
                     1'b1, SYNC,            1'b0};
        ovr_set_c = result_valid && (state != IDLE) && pend_full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sum       <= '0;
            dvd       <= '0;
            rem       <= '0;
            div_cnt   <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            frame     <= '0;
            bit_pos   <= '0;
            clk_cnt   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            avg_valid <= 1'b0;

            if (ovr_set_c) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            // A full buffer in IDLE is consumed this cycle, so a new sum refills it
            if (result_valid && ((state != IDLE) || pend_full)) begin
                pend      <= result;
                pend_full <= 1'b1;
            end else if ((state == IDLE) && pend_full) begin
                pend_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pend_full || result_valid) begin
                        sum   <= pend_full ? pend : result;
                        busy  <= 1'b1;
                        state <= SUB;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SUB: begin
                    dvd     <= adj_c;
                    rem     <= '0;
                    div_cnt <= '0;
                    state   <= DIV;
                end
                DIV: begin
                    dvd     <= {dvd[SUM_W-2:0], q_bit_c};
                    rem     <= rem_next_c;
                    div_cnt <= div_cnt + DIV_W'(1);
                    if (div_cnt == DIV_W'(SUM_W - 1)) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    avg_out   <= avg_sat_c;
                    avg_valid <= 1'b1;
                    frame     <= frame_c;
                    bit_pos   <= '0;
                    clk_cnt   <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    tx <= frame[bit_pos];
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (bit_pos == POS_W'(FRAME_W - 1)) begin
                            state <= IDLE;
                        end else begin
                            bit_pos <= bit_pos + POS_W'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_avg_tx.sv
// Directed testbench for accum_avg_tx: mean computation, frame contents and
// timing, pending buffer / overrun behaviour and asynchronous reset.
`timescale 1ns/1ps

module tb_accum_avg_tx;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] result = '0;
    logic        result_valid = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        tx;
    logic        busy;
    logic [15:0] avg_out;
    logic        avg_valid;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    accum_avg_tx #(
        .CLKS_PER_BIT(CPB),
        .N_SAMPLES(9),
        .SUM_OFFSET(162)
    ) dut (
        .clk(clk),
        .rst(rst),
        .result(result),
        .result_valid(result_valid),
        .ovr_clr(ovr_clr),
        .tx(tx),
        .busy(busy),
        .avg_out(avg_out),
        .avg_valid(avg_valid),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Presents v for exactly one rising edge; returns half a cycle after it.
    task automatic strobe(input logic [19:0] v);
        @(negedge clk);
        result       = v;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    // Entered half a cycle after the edge that loaded the sum; follows the
    // whole computation and frame and returns half a cycle after busy should fall.
    task automatic expect_frame(input logic [15:0] exp_avg, input string name,
                                input bit idle_after);
        logic [7:0] exp_b [4];
        logic [7:0] got;
        logic [9:0] sym;
        exp_b[0] = 8'hA5;
        exp_b[1] = exp_avg[15:8];
        exp_b[2] = exp_avg[7:0];
        exp_b[3] = 8'hA5 ^ exp_avg[15:8] ^ exp_avg[7:0];

        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_rise: got %b expected 1", name, busy);
        end
        repeat (21) @(negedge clk);
        checks++;
        if (avg_valid !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL %s pre_sat: got avg_valid=%b tx=%b expected 0/1", name, avg_valid, tx);
        end
        @(negedge clk);
        checks++;
        if (avg_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s avg_valid_pulse: got %b expected 1", name, avg_valid);
        end
        checks++;
        if (avg_out !== exp_avg) begin
            failures++;
            $display("FAIL %s avg_out: got %h expected %h", name, avg_out, exp_avg);
        end
        @(negedge clk);
        checks++;
        if (avg_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s avg_valid_width: got %b expected 0", name, avg_valid);
        end
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL %s start_edge: got tx=%b expected 0", name, tx);
        end
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                sym[i] = tx;
                if (!(b == 3 && i == 9)) repeat (CPB) @(negedge clk);
            end
            got = sym[8:1];
            checks++;
            if (sym[0] !== 1'b0 || sym[9] !== 1'b1) begin
                failures++;
                $display("FAIL %s framing byte%0d: got start=%b stop=%b expected 0/1",
                         name, b, sym[0], sym[9]);
            end
            checks++;
            if (got !== exp_b[b]) begin
                failures++;
                $display("FAIL %s byte%0d: got %h expected %h", name, b, got, exp_b[b]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL %s last_stop: got busy=%b tx=%b expected 1/1", name, busy, tx);
        end
        @(negedge clk);
        checks++;
        if (busy !== (idle_after ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL %s busy_end: got %b expected %b", name, busy, !idle_after);
        end
        checks++;
        if (avg_out !== exp_avg || tx !== 1'b1) begin
            failures++;
            $display("FAIL %s hold: got avg_out=%h tx=%b expected %h/1", name, avg_out, tx, exp_avg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || avg_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got tx=%b busy=%b avg_valid=%b expected 1/0/0", tx, busy, avg_valid);
        end
        checks++;
        if (avg_out !== 16'h0000 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got avg_out=%h overrun=%b expected 0000/0", avg_out, overrun);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b tx=%b expected 0/1", busy, tx);
        end
    endtask

    task automatic test_nominal();
        strobe(20'd9162);
        expect_frame(16'h03E8, "nominal", 1'b1);
    endtask

    task automatic test_underflow();
        strobe(20'd100);
        expect_frame(16'h0000, "underflow", 1'b1);
    endtask

    task automatic test_saturation();
        strobe(20'hFFFFF);
        expect_frame(16'hFFFF, "saturation", 1'b1);
    endtask

    task automatic test_back_to_back();
        strobe(20'd9162);
        fork
            expect_frame(16'h03E8, "b2b_first", 1'b0);
            begin
                repeat (60) @(negedge clk);
                strobe(20'd18162);
                repeat (40) @(negedge clk);
                strobe(20'd27162);
            end
        join
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_overrun_set: got %b expected 1", overrun);
        end
        expect_frame(16'h0BB8, "b2b_second", 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_overrun_sticky: got %b expected 1", overrun);
        end
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overrun_clr: got %b expected 0", overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        strobe(20'd9162);
        repeat (20) @(negedge clk);
        strobe(20'd18162);
        repeat (10) @(negedge clk);
        @(negedge clk);
        result       = 20'd27162;
        result_valid = 1'b1;
        ovr_clr      = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        ovr_clr      = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clr: got overrun=%b expected 1", overrun);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_busy: got %b expected 1", busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got tx=%b busy=%b overrun=%b expected 1/0/0", tx, busy, overrun);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || avg_valid !== 1'b0) begin
            failures++;
            $display("FAIL pending_dropped: got busy=%b tx=%b avg_valid=%b expected 0/1/0", busy, tx, avg_valid);
        end
        strobe(20'd18162);
        expect_frame(16'h07D0, "after_reset", 1'b1);
    endtask

    task automatic test_div_sweep();
        logic [19:0] sums [6];
        logic [15:0] avgs [6];
        sums[0] = 20'd162;   avgs[0] = 16'd0;
        sums[1] = 20'd170;   avgs[1] = 16'd0;
        sums[2] = 20'd171;   avgs[2] = 16'd1;
        sums[3] = 20'd179;   avgs[3] = 16'd1;
        sums[4] = 20'd65691; avgs[4] = 16'd7281;
        sums[5] = 20'd65699; avgs[5] = 16'd7281;
        for (int n = 0; n < 6; n++) begin
            strobe(sums[n]);
            expect_frame(avgs[n], $sformatf("sweep%0d", n), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_underflow();
        test_saturation();
        test_back_to_back();
        test_reset_mid_frame();
        test_div_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
